// File: rtl/rip_seq_ctrl_if.sv
// Handshake and operand/result bundle for rip_seq_ctrl.
// The i_/o_ prefixes name each signal's direction as seen from the sequencer.
interface rip_seq_ctrl_if #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
);
  localparam int W = SIZE * WORDS;

  logic         i_start;
  logic         i_sub;
  logic         i_cin;
  logic [W-1:0] i_a_in;
  logic [W-1:0] i_b_in;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  modport slave (
    input  i_start, i_sub, i_cin, i_a_in, i_b_in,
    output o_busy, o_done, o_sum, o_cout, o_ovf
  );

  modport master (
    output i_start, i_sub, i_cin, i_a_in, i_b_in,
    input  o_busy, o_done, o_sum, o_cout, o_ovf
  );
endinterface

// File: rtl/rip_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one SIZE-bit ripple adder is walked
// across WORDS words, LSW first, with the carry registered between words.

module rip #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_sum,
  output logic [SIZE-1:0] o_carry
);
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bit
      logic w_ci;
      logic w_co;
      // Per-bit carry wires keep the chain acyclic at the vector level.
      if (gi == 0) begin : g_lsb
        assign w_ci = i_cin;
      end else begin : g_upper
        assign w_ci = g_bit[gi-1].w_co;
      end
      assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_ci;
      assign w_co        = (i_a[gi] & i_b[gi]) | (w_ci & (i_a[gi] ^ i_b[gi]));
      assign o_carry[gi] = w_co;
    end
  endgenerate
endmodule

module rip_seq_ctrl #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rip_seq_ctrl_if.slave       bus
);
  localparam int W    = SIZE * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_last;

  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_sub;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [SIZE-1:0] w_a_word;
  logic [SIZE-1:0] w_b_word;
  logic [SIZE-1:0] w_add_sum;
  logic [SIZE-1:0] w_add_carry;

  // Word selection from the latched operands; subtraction inverts b and
  // relies on carry_q having been preset to 1 at accept.
  assign w_a_word = r_a[int'(r_idx) * SIZE +: SIZE];
  assign w_b_word = r_sub ? ~r_b[int'(r_idx) * SIZE +: SIZE]
                          :  r_b[int'(r_idx) * SIZE +: SIZE];

  rip #(.SIZE(SIZE)) u_rip (
    .i_a     (w_a_word),
    .i_b     (w_b_word),
    .i_cin   (r_carry),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.i_a_in;
      r_b     <= bus.i_b_in;
      r_sub   <= bus.i_sub;
      r_idx   <= '0;
      r_carry <= bus.i_sub ? 1'b1 : bus.i_cin;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[int'(r_idx) * SIZE +: SIZE] <= w_add_sum;
      r_carry <= w_add_carry[SIZE-1];
      if (w_last) begin
        // Signed overflow: carry into the MSB differs from carry out of it.
        r_cout <= w_add_carry[SIZE-1];
        r_ovf  <= w_add_carry[SIZE-1] ^ w_add_carry[SIZE-2];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = (r_state == S_DONE);
  assign bus.o_sum  = r_sum;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_rip_seq_ctrl.sv
// Scoreboard bench for rip_seq_ctrl (SIZE=4, WORDS=4): directed vectors push
// expected results, a negedge monitor pops and compares on every done pulse.
module tb_rip_seq_ctrl;
  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rip_seq_ctrl_if #(.SIZE(SIZE), .WORDS(WORDS)) bus ();

  rip_seq_ctrl #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   busy_cyc = 0;
  int   done_cyc = 0;
  logic prev_c = 1'b0;
  logic prev_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: counts busy/done cycles and checks each result against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_busy) busy_cyc++;
      if (bus.o_done) begin
        done_cyc++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("result{sum,cout,ovf}", {14'd0, bus.o_sum, bus.o_cout, bus.o_ovf},
                {14'd0, mon_e.s, mon_e.c, mon_e.v});
          $display("done: sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
                   bus.o_sum, bus.o_cout, bus.o_ovf, mon_e.s, mon_e.c, mon_e.v);
        end
      end
    end
  end

  task automatic drive(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_sub  = sub;
    bus.i_cin  = cin;
    bus.i_a_in = a;
    bus.i_b_in = b;
  endtask

  // Issue a one-cycle start pulse and check the accept-edge side effects.
  task automatic start_op(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(sub, cin, a, b);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check("busy_after_accept", {31'd0, bus.o_busy}, 32'd1);
    check("sum_cleared", {16'd0, bus.o_sum}, 32'd0);
    check("cout_held", {31'd0, bus.o_cout}, {31'd0, prev_c});
    check("ovf_held", {31'd0, bus.o_ovf}, {31'd0, prev_v});
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cyc == d0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cyc == d0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] s, input logic c, input logic v);
    int b0;
    int d0;
    exp_t e;
    e.s = s; e.c = c; e.v = v;
    sb_q.push_back(e);
    b0 = busy_cyc;
    d0 = done_cyc;
    start_op(sub, cin, a, b);
    wait_done(d0, "op");
    @(negedge clk);
    #1;
    check("busy_low_in_idle", {31'd0, bus.o_busy}, 32'd0);
    check("busy_cycles", busy_cyc - b0, 32'd5);
    check("done_cycles", done_cyc - d0, 32'd1);
    check("held_result", {14'd0, bus.o_sum, bus.o_cout, bus.o_ovf}, {14'd0, s, c, v});
    prev_c = c;
    prev_v = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   d0;
    bus.i_start = 1'b0;
    drive(1'b0, 1'b0, '0, '0);

    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, bus.o_busy, bus.o_done, bus.o_sum, bus.o_cout, bus.o_ovf}, 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 16'h1234, 16'h0000, 16'h1235, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op(1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    run_op(1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);

    // Second start pulsed at E2 must be ignored; then start held through DONE.
    e.s = 16'h3333; e.c = 1'b0; e.v = 1'b0;
    sb_q.push_back(e);
    d0 = done_cyc;
    start_op(1'b0, 1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hFFFF, 16'h0FFF);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done(d0, "ignored_start_op");
    check("single_done", done_cyc - d0, 32'd1);
    prev_c = 1'b0;
    prev_v = 1'b0;
    drive(1'b0, 1'b0, 16'h0F0F, 16'h0101);
    bus.i_start = 1'b1;
    e.s = 16'h1010; e.c = 1'b0; e.v = 1'b0;
    sb_q.push_back(e);
    d0 = done_cyc;
    @(negedge clk);
    #1;
    check("start_in_done_ignored", {31'd0, bus.o_busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check("held_start_accept", {31'd0, bus.o_busy}, 32'd1);
    check("held_start_sum_cleared", {16'd0, bus.o_sum}, 32'd0);
    wait_done(d0, "held_start_op");
    @(negedge clk);
    #1;
    check("held_start_done_cycles", done_cyc - d0, 32'd1);

    // Reset between E2 and E3 discards the operation.
    d0 = done_cyc;
    start_op(1'b0, 1'b0, 16'h00FF, 16'h0001);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {12'd0, bus.o_busy, bus.o_done, bus.o_sum, bus.o_cout, bus.o_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("no_done_after_reset", done_cyc - d0, 32'd0);
    prev_c = 1'b0;
    prev_v = 1'b0;
    run_op(1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
